// File: rtl/cmd_sched_pkg.sv
// rtl/cmd_sched_pkg.sv - shared constants and state types for the command scheduler
package cmd_sched_pkg;

  localparam int          CMD_W       = 16;
  localparam logic [7:0]  ACK_DEFAULT = 8'hA5;
  localparam logic [7:0]  NAK_DEFAULT = 8'h5A;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } disp_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - DEPTH x W synchronous FIFO with combinational head and occupancy count
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_din,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/cmd_sched.sv
// rtl/cmd_sched.sv - buffers wrapper commands, dispatches them one at a time, returns ACK/NAK bytes
module cmd_sched
  import cmd_sched_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [7:0] ACK   = ACK_DEFAULT,
  parameter logic [7:0] NAK   = NAK_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_rdy,
  input  logic [CMD_W-1:0]  i_cmd,
  output logic              o_clr_cmd_rdy,
  output logic              o_trmt,
  output logic [7:0]        o_resp,
  input  logic              i_tx_done,
  output logic              o_cmd_vld,
  output logic [CMD_W-1:0]  o_cmd_out,
  input  logic              i_cmd_accept,
  input  logic              i_cmd_cmplt,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int RW  = $clog2(DEPTH + 2);
  localparam logic [RW-1:0] R_MAX = '1;

  disp_state_t      r_disp;
  tx_state_t        r_tx;
  logic             r_clr;
  logic             r_trmt;
  logic [7:0]       r_resp;
  logic             r_ovf;
  logic [RW-1:0]    r_ack_cnt;
  logic [RW-1:0]    r_nak_cnt;

  logic [CMD_W-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic [FCW-1:0]   w_count;
  logic             w_ingest;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_cmd_vld;
  logic             w_ack_inc;
  logic             w_nak_avail;
  logic             w_ack_avail;
  logic             w_tx_start;
  logic             w_nak_dec;
  logic             w_ack_dec;

  // r_clr masks the cycle in which the wrapper still shows the level we just consumed.
  assign w_ingest  = i_cmd_rdy & ~r_clr;
  assign w_cmd_vld = (r_disp == IDLE) & ~w_empty;
  assign w_pop     = w_cmd_vld & i_cmd_accept;
  assign w_push    = w_ingest & ((w_count < FCW'(DEPTH)) | w_pop);
  assign w_drop    = w_ingest & w_full & ~w_pop;
  assign w_ack_inc = (r_disp == BUSY) & i_cmd_cmplt;

  // Same-cycle events count as pending so a response can start without a counter round trip.
  assign w_nak_avail = (r_nak_cnt != '0) | w_drop;
  assign w_ack_avail = (r_ack_cnt != '0) | w_ack_inc;
  assign w_tx_start  = (r_tx == TX_IDLE) & (w_nak_avail | w_ack_avail);
  assign w_nak_dec   = w_tx_start & w_nak_avail;
  assign w_ack_dec   = w_tx_start & ~w_nak_avail;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_cmd),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clr  <= 1'b0;
      r_ovf  <= 1'b0;
      r_disp <= IDLE;
    end else begin
      r_clr <= w_ingest;
      r_ovf <= r_ovf | w_drop;
      unique case (r_disp)
        IDLE:    if (w_pop)       r_disp <= BUSY;
        BUSY:    if (i_cmd_cmplt) r_disp <= IDLE;
        default: r_disp <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_nak_cnt <= '0;
      r_ack_cnt <= '0;
    end else begin
      if (w_drop && !w_nak_dec) begin
        if (r_nak_cnt != R_MAX) r_nak_cnt <= r_nak_cnt + 1'b1;
      end else if (w_nak_dec && !w_drop) begin
        r_nak_cnt <= r_nak_cnt - 1'b1;
      end
      if (w_ack_inc && !w_ack_dec) begin
        if (r_ack_cnt != R_MAX) r_ack_cnt <= r_ack_cnt + 1'b1;
      end else if (w_ack_dec && !w_ack_inc) begin
        r_ack_cnt <= r_ack_cnt - 1'b1;
      end
    end
  end

  // tx_done is ignored while r_trmt is high so a level left over from the previous byte cannot end this one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx   <= TX_IDLE;
      r_trmt <= 1'b0;
      r_resp <= 8'h00;
    end else begin
      r_trmt <= w_tx_start;
      unique case (r_tx)
        TX_IDLE: begin
          if (w_tx_start) begin
            r_tx   <= TX_WAIT;
            r_resp <= w_nak_avail ? NAK : ACK;
          end
        end
        TX_WAIT: if (!r_trmt && i_tx_done) r_tx <= TX_IDLE;
        default: r_tx <= TX_IDLE;
      endcase
    end
  end

  assign o_clr_cmd_rdy = r_clr;
  assign o_trmt        = r_trmt;
  assign o_resp        = r_resp;
  assign o_cmd_vld     = w_cmd_vld;
  assign o_cmd_out     = w_cmd_vld ? w_head : '0;
  assign o_busy        = (r_disp == BUSY);
  assign o_overflow    = r_ovf;

endmodule

// File: doc/cmd_sched.md
# cmd_sched

Command scheduler between the UART_wrapper and the command processor of the knight's-tour robot. Accepts 16-bit commands from the wrapper's `cmd_rdy`/`cmd` handshake, buffers them in a small FIFO, and issues them one at a time to the processor. It also owns the wrapper's transmitter, sending one ACK byte per completed command and a NAK byte per dropped command.

## Interface
- `DEPTH`, 4: command FIFO entries, power of two, 2..16.
- `ACK`, 8'hA5: response byte sent on command completion.
- `NAK`, 8'h5A: response byte sent when a command is dropped because the FIFO is full.

- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset; one clock; synchronous, active-low.
- `cmd_rdy`  in  1  UART_wrapper: 16-bit command available; held until cleared.
- `cmd`  in  16  UART_wrapper: received command.
- `clr_cmd_rdy`  out  1  to UART_wrapper: one-cycle clear pulse.
- `trmt`  out  1  to UART_wrapper: one-cycle transmit-start pulse.
- `resp`  out  8  to UART_wrapper: response byte.
- `tx_done`  in  1  UART_wrapper: transmission of `resp` finished.
- `cmd_vld`  out  1  command offered to processor.
- `cmd_out`  out  16  offered command (FIFO head).
- `cmd_accept`  in  1  processor takes `cmd_out`.
- `cmd_cmplt`  in  1  processor finished the accepted command (one-cycle pulse).
- `busy`  out  1  a command is accepted and not yet complete.
- `overflow`  out  1  sticky: at least one command was dropped since reset.

## Operation
- **Reset** (`rst_n` low at a posedge) empties the FIFO, clears pending ACK/NAK counts and returns both FSMs to IDLE.
  - All outputs are 0 after reset, including `cmd_out` (16'h0000) and `resp` (8'h00).
  - A byte already in flight in the wrapper is abandoned; its `tx_done` is ignored.
- **Ingest**
  - Ingest happens when `cmd_rdy` & ~`clr_cmd_rdy`.
  - `clr_cmd_rdy` is registered high for exactly the next cycle. This guard prevents double-ingesting a held `cmd_rdy`.
  - The command is pushed if count < `DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the command is dropped, `clr_cmd_rdy` still pulses, `overflow` sets, and the NAK count increments.
- **Dispatch FSM**: states IDLE and BUSY.
  - `cmd_vld` = IDLE & FIFO not empty. `cmd_out` = head when `cmd_vld`, else 16'h0000.
  - IDLE→BUSY on `cmd_vld` & `cmd_accept`; the head pops that cycle.
  - BUSY→IDLE on `cmd_cmplt`; the ACK count increments.
  - `cmd_cmplt` in IDLE is ignored. `busy` = (state==BUSY).
  - Only one command is outstanding at a time. The next dispatch may proceed before its ACK is transmitted.
- **Response FSM**: states TX_IDLE and TX_WAIT.
  - In TX_IDLE, if NAK count > 0, drive `resp`=`NAK`, pulse `trmt` and decrement the NAK count; otherwise do the same with the ACK count and `ACK`. Go to TX_WAIT.
  - NAK has priority over ACK.
  - `resp` is held stable from the `trmt` cycle until leaving TX_WAIT.
  - TX_WAIT→TX_IDLE on `tx_done` sampled high. `tx_done` is only sampled from the cycle after `trmt`, so a stale level is never taken as completion.
  - ACK and NAK counts are clog2(`DEPTH`+2) bits and saturate at max. An increment and a decrement in the same cycle leave the count unchanged.

## Timing
- `cmd_rdy` rise → `clr_cmd_rdy` high on the following cycle.
- With an empty FIFO, `cmd_vld` is high on that same following cycle (1-cycle latency).
- `cmd_accept` in cycle N → `cmd_vld` low from N+1 and `busy` high from N+1.
- `cmd_cmplt` in cycle N:
  - `busy` low from N+1;
  - `trmt` pulses at N+1 if the response FSM is idle and no NAK is pending;
  - if the FIFO is non-empty, the next `cmd_vld` is high at N+1.
- After `tx_done`, the earliest next `trmt` is 1 cycle later (back-to-back responses have a 1-cycle gap).
- Full FIFO with a simultaneous accept-pop and ingest: the push is accepted and the count is unchanged.

## Structure
- `cmd_sched_pkg` holds:
  - the `ACK`/`NAK` default constants;
  - `disp_state_t` (IDLE, BUSY);
  - `tx_state_t` (TX_IDLE, TX_WAIT).
- Sub-module `cmd_fifo`: parameterized DEPTH×16 synchronous FIFO.
  - Ports: push, pop, din, dout (combinational head), full, empty, count.
  - Reset is synchronous, active-low.
- The top level holds the ingest guard, both FSMs and the counters.

## Test plan
- Single command: `cmd`=16'h1234 with `cmd_rdy` → `clr_cmd_rdy` pulse; `cmd_vld` with `cmd_out`=16'h1234 one cycle later; accept, then `cmd_cmplt` → `trmt` with `resp`=8'hA5; `tx_done` returns to idle.
- Burst: 4 commands 16'hAF82, 16'h0001, 16'h0002, 16'h0003 while the processor stalls → all buffered and dispatched in order; 4 ACKs sent, each `trmt` after the prior `tx_done`.
- Overflow: 5 commands with no accept and `DEPTH`=4 → 5th dropped with `clr_cmd_rdy` still pulsed; `overflow`=1; NAK 8'h5A is the first byte sent, before any ACK.
- Held `cmd_rdy`: keep `cmd_rdy` high 3 cycles after `clr_cmd_rdy` → exactly one push per clear pulse, with no duplicate entries.
- Full with simultaneous pop and push → count stays 4, no NAK, order preserved.
- Mid-operation reset: assert `rst_n`=0 in BUSY with 2 queued and the TX FSM in TX_WAIT → next cycle all outputs 0 and FIFO empty; a late `tx_done` is ignored.
